// File: rtl/l2_dmem_mp_if.sv
`default_nettype none
// ============================================================================
//  Module      : l2_dmem_mp_if
//  Description : Request / read-response bundle shared by all ports of the
//                multi-port L2 data memory. Vectors are packed per port.
//  Revision    : 1.0 - initial release
// ============================================================================
interface l2_dmem_mp_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 256
) ();
  logic [NUM_PORTS-1:0]          req;
  logic [NUM_PORTS-1:0]          we;
  logic [NUM_PORTS*ADDR_W-1:0]   addr;
  logic [NUM_PORTS*DATA_W-1:0]   wdata;
  logic [NUM_PORTS*DATA_W/8-1:0] be;
  logic [NUM_PORTS-1:0]          gnt;
  logic [NUM_PORTS-1:0]          rsp_valid;
  logic [NUM_PORTS*DATA_W-1:0]   rsp_data;
  logic [NUM_PORTS-1:0]          rsp_ready;

  // Requestor side
  modport master (
    output req, we, addr, wdata, be, rsp_ready,
    input  gnt, rsp_valid, rsp_data
  );

  // Memory side
  modport slave (
    input  req, we, addr, wdata, be, rsp_ready,
    output gnt, rsp_valid, rsp_data
  );
endinterface
`default_nettype wire

// File: rtl/l2_dmem_mp.sv
`default_nettype none
// ============================================================================
//  Module      : l2_dmem_mp
//  Description : Multi-port, word-interleaved, multi-bank L2 data memory.
//                Per-bank round-robin arbitration, byte-enabled writes and a
//                credit-limited in-order read-response FIFO per port.
//  Revision    : 1.0 - initial release
// ============================================================================
module l2_dmem_mp #(
  parameter int NUM_PORTS = 2,
  parameter int NUM_BANKS = 4,
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 256,
  parameter int RSP_DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  l2_dmem_mp_if.slave   mem_if
);

  localparam int c_bank_w = $clog2(NUM_BANKS);
  localparam int c_row_w  = ADDR_W - c_bank_w;
  localparam int c_rows   = 1 << c_row_w;
  localparam int c_port_w = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int c_be_w   = DATA_W / 8;
  localparam int c_cnt_w  = $clog2(RSP_DEPTH + 1);
  localparam int c_ptr_w  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  // Per-port request fields
  logic [c_bank_w-1:0] bank_of_w [NUM_PORTS];
  logic [c_row_w-1:0]  row_of_w  [NUM_PORTS];
  logic [DATA_W-1:0]   wdata_w   [NUM_PORTS];
  logic [c_be_w-1:0]   be_w      [NUM_PORTS];
  logic [NUM_PORTS-1:0] elig_w;
  logic [NUM_PORTS-1:0] gnt_w;

  // Per-bank arbitration and access
  logic [NUM_BANKS-1:0] arb_vld_w;
  logic [NUM_BANKS-1:0] arb_go_w;
  logic [c_port_w-1:0]  arb_win_w    [NUM_BANKS];
  logic [c_port_w-1:0]  rr_ptr_q     [NUM_BANKS];
  logic [c_port_w-1:0]  rr_ptr_d     [NUM_BANKS];
  logic [NUM_BANKS-1:0] bank_we_w;
  logic [c_row_w-1:0]   bank_row_w   [NUM_BANKS];
  logic [DATA_W-1:0]    bank_wdata_w [NUM_BANKS];
  logic [c_be_w-1:0]    bank_be_w    [NUM_BANKS];
  logic [DATA_W-1:0]    bank_rdata_w [NUM_BANKS];

  // Outputs assembled per port
  logic [NUM_PORTS-1:0]        rsp_valid_w;
  logic [NUM_PORTS*DATA_W-1:0] rsp_data_w;

  // Per-bank round-robin: lowest eligible port overall is the fallback, the
  // lowest eligible port at or after the pointer overrides it.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      arb_vld_w[b] = 1'b0;
      arb_win_w[b] = '0;
      for (int p = NUM_PORTS - 1; p >= 0; p--) begin
        if (elig_w[p] && (bank_of_w[p] == c_bank_w'(b))) begin
          arb_vld_w[b] = 1'b1;
          arb_win_w[b] = c_port_w'(p);
        end
      end
      for (int p = NUM_PORTS - 1; p >= 0; p--) begin
        if (elig_w[p] && (bank_of_w[p] == c_bank_w'(b)) &&
            (c_port_w'(p) >= rr_ptr_q[b])) begin
          arb_win_w[b] = c_port_w'(p);
        end
      end
    end
  end

  // Steer the winning port's fields onto each bank and advance the pointer
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      arb_go_w[b]     = arb_vld_w[b] & ~rst;
      bank_we_w[b]    = 1'b0;
      bank_row_w[b]   = '0;
      bank_wdata_w[b] = '0;
      bank_be_w[b]    = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (arb_win_w[b] == c_port_w'(p)) begin
          bank_we_w[b]    = mem_if.we[p];
          bank_row_w[b]   = row_of_w[p];
          bank_wdata_w[b] = wdata_w[p];
          bank_be_w[b]    = be_w[p];
        end
      end
      rr_ptr_d[b] = rr_ptr_q[b];
      if (arb_vld_w[b]) begin
        rr_ptr_d[b] = (arb_win_w[b] == c_port_w'(NUM_PORTS - 1)) ? '0
                                                                 : arb_win_w[b] + 1'b1;
      end
    end
  end

  // A port is granted when some bank picked it; nothing is granted in reset
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      gnt_w[p] = 1'b0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (arb_go_w[b] && (arb_win_w[b] == c_port_w'(p))) gnt_w[p] = 1'b1;
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_W-1:0] mem_q [c_rows];
    logic [DATA_W-1:0] rdata_q;

    // Round-robin pointer for this bank
    always_ff @(posedge clk or posedge rst) begin
      if (rst) rr_ptr_q[b] <= '0;
      else     rr_ptr_q[b] <= rr_ptr_d[b];
    end

    // Storage array: contents deliberately survive reset
    always_ff @(posedge clk) begin
      if (arb_go_w[b]) begin
        if (bank_we_w[b]) begin
          for (int i = 0; i < c_be_w; i++) begin
            if (bank_be_w[b][i]) mem_q[bank_row_w[b]][i*8 +: 8] <= bank_wdata_w[b][i*8 +: 8];
          end
        end else begin
          rdata_q <= mem_q[bank_row_w[b]];
        end
      end
    end

    assign bank_rdata_w[b] = rdata_q;
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [c_cnt_w-1:0] out_cnt_q, out_cnt_d;
    logic [c_cnt_w-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [c_ptr_w-1:0] wr_ptr_q, rd_ptr_q;
    logic               rd_pend_q;
    logic [c_bank_w-1:0] rd_bank_q;
    logic [DATA_W-1:0]  fifo_q [RSP_DEPTH];
    logic               rd_gnt_w, push_w, pop_w;

    assign bank_of_w[p] = mem_if.addr[p*ADDR_W +: c_bank_w];
    assign row_of_w[p]  = mem_if.addr[p*ADDR_W + c_bank_w +: c_row_w];
    assign wdata_w[p]   = mem_if.wdata[p*DATA_W +: DATA_W];
    assign be_w[p]      = mem_if.be[p*c_be_w +: c_be_w];
    // Reads need a free credit so the FIFO can never overflow
    assign elig_w[p]    = mem_if.req[p] & (mem_if.we[p] | (out_cnt_q < c_cnt_w'(RSP_DEPTH)));

    assign rd_gnt_w = gnt_w[p] & ~mem_if.we[p];
    assign push_w   = rd_pend_q;
    assign pop_w    = (fifo_cnt_q != '0) & mem_if.rsp_ready[p];

    // Next-state for the credit counter and FIFO occupancy
    always_comb begin
      out_cnt_d = out_cnt_q;
      if (rd_gnt_w && !pop_w)      out_cnt_d = out_cnt_q + 1'b1;
      else if (!rd_gnt_w && pop_w) out_cnt_d = out_cnt_q - 1'b1;
      fifo_cnt_d = fifo_cnt_q;
      if (push_w && !pop_w)        fifo_cnt_d = fifo_cnt_q + 1'b1;
      else if (!push_w && pop_w)   fifo_cnt_d = fifo_cnt_q - 1'b1;
    end

    // Control state: read pipeline tag, credits and FIFO pointers
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_pend_q  <= 1'b0;
        rd_bank_q  <= '0;
        out_cnt_q  <= '0;
        fifo_cnt_q <= '0;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
      end else begin
        rd_pend_q  <= rd_gnt_w;
        rd_bank_q  <= bank_of_w[p];
        out_cnt_q  <= out_cnt_d;
        fifo_cnt_q <= fifo_cnt_d;
        if (push_w) wr_ptr_q <= ptr_inc(wr_ptr_q);
        if (pop_w)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
    end

    // FIFO payload; output is masked while empty so no reset is needed
    always_ff @(posedge clk) begin
      if (push_w) fifo_q[wr_ptr_q] <= bank_rdata_w[rd_bank_q];
    end

    assign rsp_valid_w[p] = (fifo_cnt_q != '0);
    assign rsp_data_w[p*DATA_W +: DATA_W] = rsp_valid_w[p] ? fifo_q[rd_ptr_q] : '0;
  end

  function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] ptr);
    return (ptr == c_ptr_w'(RSP_DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign mem_if.gnt       = gnt_w;
  assign mem_if.rsp_valid = rsp_valid_w;
  assign mem_if.rsp_data  = rsp_data_w;

endmodule
`default_nettype wire

// File: tb/tb_l2_dmem_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_l2_dmem_mp
//  Description : Self-checking bench for l2_dmem_mp with a reference memory
//                model and per-port in-order response scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_l2_dmem_mp;
  localparam int NUM_PORTS = 2;
  localparam int NUM_BANKS = 4;
  localparam int ADDR_W    = 11;
  localparam int DATA_W    = 256;
  localparam int RSP_DEPTH = 2;
  localparam int BE_W      = DATA_W / 8;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    logic [DATA_W-1:0] data;
    int                gcyc;
  } exp_t;

  exp_t              sb_q [NUM_PORTS][$];
  logic [DATA_W-1:0] mdl [int];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  l2_dmem_mp_if #(.NUM_PORTS(NUM_PORTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  l2_dmem_mp #(
    .NUM_PORTS(NUM_PORTS), .NUM_BANKS(NUM_BANKS), .ADDR_W(ADDR_W),
    .DATA_W(DATA_W), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .mem_if(bus)
  );

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_v,
                                              input logic [DATA_W-1:0] new_v,
                                              input logic [BE_W-1:0] b);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < BE_W; i++) r[i*8 +: 8] = b[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] rep32(input logic [31:0] w);
    return {8{w}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input bit w, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic [BE_W-1:0] b);
    bus.req[p] = 1'b1;
    bus.we[p]  = w;
    bus.addr[p*ADDR_W +: ADDR_W] = a;
    bus.wdata[p*DATA_W +: DATA_W] = d;
    bus.be[p*BE_W +: BE_W] = b;
  endtask

  task automatic idle(input int p);
    bus.req[p] = 1'b0;
    bus.we[p]  = 1'b0;
  endtask

  // Hold a request until granted; returns at the start of the next cycle
  task automatic issue(input int p, input bit w, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d, input logic [BE_W-1:0] b,
                       output int gcyc, output int waited);
    waited = 0;
    gcyc = -1;
    drive(p, w, a, d, b);
    while (waited < 40) begin
      @(negedge clk);
      if (bus.gnt[p]) begin
        gcyc = cyc;
        break;
      end
      tick();
      waited++;
    end
    if (gcyc < 0) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout port=%0d addr=%h got=no_gnt exp=gnt", p, a);
    end
    tick();
    idle(p);
  endtask

  task automatic wait_rsp(input int p, output logic [DATA_W-1:0] d, output bit ok);
    ok = 1'b0;
    d  = '0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.rsp_valid[p]) begin
        d  = bus.rsp_data[p*DATA_W +: DATA_W];
        ok = 1'b1;
        break;
      end
    end
    tick();
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int n = 0; n < 30 && !done; n++) begin
      @(negedge clk);
      #1;
      done = (sb_q[0].size() == 0) && (sb_q[1].size() == 0);
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL drain got=%0d/%0d_pending exp=0/0", sb_q[0].size(), sb_q[1].size());
    end
    tick();
  endtask

  // Scoreboard: model writes, queue expected read data, compare on pop
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int p = 0; p < NUM_PORTS; p++) sb_q[p].delete();
        continue;
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
        logic [ADDR_W-1:0] a;
        exp_t e;
        a = bus.addr[p*ADDR_W +: ADDR_W];
        checks++;
        if (bus.gnt[p] && !bus.req[p]) begin
          failures++;
          $display("FAIL gnt_without_req port=%0d got=gnt exp=no_gnt", p);
        end
        if (bus.gnt[p]) begin
          if (bus.we[p]) begin
            mdl[int'(a)] = merge(mdl.exists(int'(a)) ? mdl[int'(a)] : '0,
                                 bus.wdata[p*DATA_W +: DATA_W], bus.be[p*BE_W +: BE_W]);
          end else begin
            e.data = mdl.exists(int'(a)) ? mdl[int'(a)] : '0;
            e.gcyc = cyc;
            sb_q[p].push_back(e);
          end
        end
      end
      if (bus.gnt[0] && bus.gnt[1]) begin
        logic [ADDR_W-1:0] a0, a1;
        a0 = bus.addr[0 +: ADDR_W];
        a1 = bus.addr[ADDR_W +: ADDR_W];
        checks++;
        if (a0[1:0] == a1[1:0]) begin
          failures++;
          $display("FAIL bank_double_grant got=bank%0d_twice exp=one_grant", a0[1:0]);
        end
      end
      for (int p = 0; p < NUM_PORTS; p++) begin
        logic [DATA_W-1:0] d;
        exp_t e;
        d = bus.rsp_data[p*DATA_W +: DATA_W];
        checks++;
        if (bus.rsp_valid[p]) begin
          if (sb_q[p].size() == 0) begin
            failures++;
            $display("FAIL sb_spurious port=%0d got=rsp_valid exp=none_outstanding", p);
          end else if (bus.rsp_ready[p]) begin
            e = sb_q[p].pop_front();
            if (d !== e.data || (cyc - e.gcyc) < 2) begin
              failures++;
              $display("FAIL sb_data port=%0d lat=%0d got=%h exp=%h", p, cyc - e.gcyc, d, e.data);
            end
          end
        end else if (d !== '0) begin
          failures++;
          $display("FAIL idle_data port=%0d got=%h exp=0", p, d);
        end
        checks++;
        if (sb_q[p].size() > RSP_DEPTH) begin
          failures++;
          $display("FAIL credit_overrun port=%0d got=%0d exp<=%0d", p, sb_q[p].size(), RSP_DEPTH);
        end
      end
    end
  endtask

  task automatic test_reset();
    drive(0, 1'b1, 11'h7FF, '1, '1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (bus.gnt !== 2'b00) begin
        failures++;
        $display("FAIL reset_gnt got=%b exp=00", bus.gnt);
      end
      checks++;
      if (bus.rsp_valid !== 2'b00) begin
        failures++;
        $display("FAIL reset_rsp_valid got=%b exp=00", bus.rsp_valid);
      end
      checks++;
      if (bus.rsp_data !== '0) begin
        failures++;
        $display("FAIL reset_rsp_data got=%h exp=0", bus.rsp_data);
      end
      tick();
    end
    idle(0);
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    int g, w, g2, w2;
    issue(0, 1'b1, 11'h005, rep32(32'hA5A5A5A5), '1, g, w);
    checks++;
    if (w != 0) begin
      failures++;
      $display("FAIL wr_gnt_latency got=%0d exp=0", w);
    end
    issue(0, 1'b0, 11'h005, '0, '0, g2, w2);
    checks++;
    if (w2 != 0) begin
      failures++;
      $display("FAIL rd_gnt_latency got=%0d exp=0", w2);
    end
    @(negedge clk);
    checks++;
    if (bus.rsp_valid[0] !== 1'b0) begin
      failures++;
      $display("FAIL rd_valid_t1 got=%b exp=0", bus.rsp_valid[0]);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.rsp_valid[0] !== 1'b1 || bus.rsp_data[0 +: DATA_W] !== rep32(32'hA5A5A5A5)) begin
      failures++;
      $display("FAIL rd_t2 got=%b/%h exp=1/%h", bus.rsp_valid[0], bus.rsp_data[0 +: DATA_W],
               rep32(32'hA5A5A5A5));
    end
    tick();
  endtask

  task automatic test_byte_enable();
    int g, w;
    logic [DATA_W-1:0] d, exp_d;
    bit ok;
    exp_d = {{(DATA_W-32){1'b1}}, 32'h0};
    issue(0, 1'b1, 11'h010, '1, '1, g, w);
    issue(0, 1'b1, 11'h010, '0, 32'h0000_000F, g, w);
    issue(0, 1'b0, 11'h010, '0, '0, g, w);
    wait_rsp(0, d, ok);
    checks++;
    if (!ok || d !== exp_d) begin
      failures++;
      $display("FAIL byte_enable got=%h exp=%h", d, exp_d);
    end
  endtask

  task automatic test_round_robin();
    int g, w;
    logic [DATA_W-1:0] d;
    bit ok;
    // Port 1 touching bank 1 leaves that bank's pointer at port 0
    issue(1, 1'b1, 11'h001, rep32(32'h0000_B001), '1, g, w);
    drive(0, 1'b0, 11'h001, '0, '0);
    drive(1, 1'b0, 11'h005, '0, '0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (bus.gnt !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
        failures++;
        $display("FAIL rr_conflict cyc%0d got=%b exp=%b", k, bus.gnt, (k % 2 == 0) ? 2'b01 : 2'b10);
      end
      tick();
    end
    idle(0);
    idle(1);
    wait_drain();
    for (int k = 0; k < 4; k++) begin
      drive(0, 1'b1, 11'h000, rep32(32'h1000_0000 + 32'(k)), '1);
      drive(1, 1'b1, 11'h001, rep32(32'h2000_0000 + 32'(k)), '1);
      @(negedge clk);
      checks++;
      if (bus.gnt !== 2'b11) begin
        failures++;
        $display("FAIL rr_parallel cyc%0d got=%b exp=11", k, bus.gnt);
      end
      tick();
    end
    idle(0);
    idle(1);
    issue(1, 1'b0, 11'h001, '0, '0, g, w);
    wait_rsp(1, d, ok);
    checks++;
    if (!ok || d !== rep32(32'h2000_0003)) begin
      failures++;
      $display("FAIL parallel_readback got=%h exp=%h", d, rep32(32'h2000_0003));
    end
  endtask

  task automatic test_backpressure();
    logic [ADDR_W-1:0] ba [4];
    int g, w, k, n;
    bit got;
    for (int i = 0; i < 4; i++) begin
      ba[i] = ADDR_W'(32'h020 + i);
      issue(1, 1'b1, ba[i], rep32(32'hC0DE_0000 + 32'(i)), '1, g, w);
    end
    bus.rsp_ready[0] = 1'b0;
    k = 0;
    drive(0, 1'b0, ba[0], '0, '0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      got = bus.gnt[0];
      checks++;
      if (got !== (c < 2)) begin
        failures++;
        $display("FAIL credit_stall cyc%0d got=%b exp=%b", c, got, (c < 2));
      end
      tick();
      if (got) begin
        k++;
        if (k < 4) drive(0, 1'b0, ba[k], '0, '0);
        else idle(0);
      end
    end
    bus.rsp_ready[0] = 1'b1;
    n = 0;
    while (k < 4 && n < 20) begin
      @(negedge clk);
      got = bus.gnt[0];
      tick();
      if (got) begin
        k++;
        if (k < 4) drive(0, 1'b0, ba[k], '0, '0);
        else idle(0);
      end
      n++;
    end
    idle(0);
    checks++;
    if (k != 4) begin
      failures++;
      $display("FAIL credit_resume got=%0d_grants exp=4", k);
    end
    wait_drain();
  endtask

  task automatic test_credit_pop_raw();
    int g, w;
    bit got;
    bit exp_pat [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [DATA_W-1:0] d;
    bit ok;
    issue(0, 1'b0, 11'h020, '0, '0, g, w);
    tick();
    drive(0, 1'b0, 11'h021, '0, '0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      got = bus.gnt[0];
      checks++;
      if (got !== exp_pat[c] || (c == 0 && bus.rsp_valid[0] !== 1'b1)) begin
        failures++;
        $display("FAIL grant_and_pop cyc%0d got=%b/v%b exp=%b", c, got, bus.rsp_valid[0], exp_pat[c]);
      end
      tick();
    end
    idle(0);
    wait_drain();
    issue(1, 1'b1, 11'h030, rep32(32'h5EED_0030), '1, g, w);
    issue(0, 1'b0, 11'h030, '0, '0, g, w);
    checks++;
    if (w != 0) begin
      failures++;
      $display("FAIL raw_gnt got=%0d_wait exp=0", w);
    end
    wait_rsp(0, d, ok);
    checks++;
    if (!ok || d !== rep32(32'h5EED_0030)) begin
      failures++;
      $display("FAIL raw_data got=%h exp=%h", d, rep32(32'h5EED_0030));
    end
  endtask

  task automatic test_reset_mid();
    int g, w;
    logic [DATA_W-1:0] d;
    bit ok;
    issue(0, 1'b0, 11'h030, '0, '0, g, w);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 2'b00) begin
        failures++;
        $display("FAIL reset_mid_valid cyc%0d got=%b exp=00", c, bus.rsp_valid);
      end
      tick();
    end
    // Both credits must be free again after reset
    bus.rsp_ready[0] = 1'b0;
    drive(0, 1'b0, 11'h030, '0, '0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (bus.gnt[0] !== 1'b1) begin
        failures++;
        $display("FAIL reset_mid_credit cyc%0d got=%b exp=1", c, bus.gnt[0]);
      end
      tick();
    end
    idle(0);
    bus.rsp_ready[0] = 1'b1;
    wait_rsp(0, d, ok);
    checks++;
    if (!ok || d !== rep32(32'h5EED_0030)) begin
      failures++;
      $display("FAIL mem_retained got=%h exp=%h", d, rep32(32'h5EED_0030));
    end
    wait_drain();
  endtask

  initial begin
    rst = 1'b1;
    bus.req = '0;
    bus.we = '0;
    bus.addr = '0;
    bus.wdata = '0;
    bus.be = '0;
    bus.rsp_ready = '1;
    fork
      begin
        tick();
        test_reset();
        test_write_read();
        test_byte_enable();
        test_round_robin();
        test_backpressure();
        test_credit_pop_raw();
        test_reset_mid();
      end
      monitor();
    join_any
    disable fork;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/l2_dmem_mp.md
Name: l2_dmem_mp

Overview:
- Parametrised multi-port, multi-bank L2 data memory.
- Word-interleaved across NUM_BANKS internal SRAM arrays. Any of NUM_PORTS requestors (core, DMA, NoC, ...) can read or write any bank.
- Each bank has a per-bank round-robin arbiter; writes support byte enables.
- Each port has a credit-limited read-response FIFO with valid/ready backpressure. It sits between the cluster core/DMA engines and L2 storage.

Parameters:
- NUM_PORTS, 2, number of requestor ports (>=1).
- NUM_BANKS, 4, number of banks (power of 2, >=2).
- ADDR_W, 11, word address width per port.
- DATA_W, 256, word width (multiple of 8).
- RSP_DEPTH, 2, per-port read-response FIFO depth = max outstanding reads per port (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req  in  NUM_PORTS  per-port request.
- we  in  NUM_PORTS  1 = write, 0 = read.
- addr  in  NUM_PORTS*ADDR_W  word address; port p at slice [p*ADDR_W +: ADDR_W].
- wdata  in  NUM_PORTS*DATA_W  write data.
- be  in  NUM_PORTS*DATA_W/8  byte enables.
- gnt  out  NUM_PORTS  request accepted this cycle.
- rsp_valid  out  NUM_PORTS  read data valid.
- rsp_data  out  NUM_PORTS*DATA_W  read data.
- rsp_ready  in  NUM_PORTS  consumer accepts read data.

Behaviour:
- Clocking/reset: one clock domain, clk. Reset is asynchronous and active-high.
- Address decode:
  - bank = addr[log2(NUM_BANKS)-1:0].
  - row = addr[ADDR_W-1:log2(NUM_BANKS)].
  - Each bank holds 2^(ADDR_W-log2(NUM_BANKS)) words.
  - No out-of-range addresses exist.
- Eligibility:
  - Port p is eligible when req[p]=1, AND either we[p]=1, or out_cnt[p] < RSP_DEPTH.
  - out_cnt[p] counts read grants not yet popped from the FIFO.
  - An ineligible read waits with gnt=0 and does not disturb the arbiter.
- Per-bank arbitration:
  - Among eligible ports targeting the bank, the first at or after rr_ptr[bank] (cyclic) wins.
  - After a grant, rr_ptr[bank] = winner+1 mod NUM_PORTS. With no grant, the pointer holds.
  - gnt is combinational, same cycle as req. Requests must hold until gnt.
  - Different banks serve different ports in the same cycle, so up to min(NUM_PORTS, NUM_BANKS) grants per cycle.
- Writes:
  - Byte lane i of the row is updated at the clock edge ending grant cycle t, only where be[i]=1.
  - A read granted at t+1 returns the new data.
  - be=0 with gnt=1 is a legal no-op write.
  - No write response.
- Reads:
  - Array read happens at grant cycle t; data is pushed into port FIFO at end of t+1.
  - rsp_valid rises at cycle t+2 at the earliest. Fixed minimum latency is 2.
  - FIFO pops on rsp_valid & rsp_ready.
  - Per-port responses return in grant order (all banks have equal latency).
- out_cnt:
  - +1 on read gnt, -1 on pop; unchanged when both occur.
  - The credit check guarantees no FIFO overflow. rsp_ready may stay low indefinitely.
- Outputs when idle: rsp_data is 0 when rsp_valid=0 (masked), and must not hold stale data.
- Reset values:
  - gnt=0 while rst=1; rsp_valid=0; rsp_data=0.
  - out_cnt=0, rr_ptr=0, FIFOs empty, in-flight reads discarded.
  - Memory contents are NOT reset and are retained across reset.
- Reset mid-operation:
  - A read granted in the cycle before rst asserts never produces a response.
  - A write whose grant edge coincides with rst assertion is not guaranteed.
- Assertions (bench):
  - No FIFO push when full.
  - No pop when empty.
  - At most one grant per bank per cycle.
  - gnt[p] implies req[p].

Test Plan:
- Reset, write then read: port0 writes addr 0x005 = 0xA5 pattern with be all-1 (gnt same cycle); port0 reads 0x005 next cycle -> rsp_valid[0] 2 cycles after gnt, data 0xA5 pattern; rsp_valid=0 during reset.
- Byte enable: write 0x010 all-FF, then write 0x010 with data 0 and be=0x0000_000F -> read returns FF except bytes 0-3 = 00.
- Bank conflict round-robin: ports 0 and 1 both read bank 1 (addrs 0x001, 0x005) continuously for 4 cycles -> grants alternate 0,1,0,1; ports on different banks (0x000, 0x001) -> both granted every cycle.
- Backpressure/credit: RSP_DEPTH=2, rsp_ready[0]=0, port0 issues 4 reads -> only 2 gnt, then gnt=0; raise rsp_ready -> the remaining reads are granted one per pop, and the 4 responses return in order.
- Simultaneous grant and pop at out_cnt=RSP_DEPTH-1 -> count unchanged, no overflow; read-after-write same address different ports in consecutive cycles -> new data.
- Reset mid-read: grant a read, assert rst the next cycle for 1 cycle -> no rsp_valid afterwards, out_cnt=0; memory contents retained on subsequent read.
